// File: rtl/pipeline_stall_controller_if.sv
// Bundle of the front-end stall/flush signals between the pipeline
// hazard sources and the stall controller.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             load_use_hz;
    logic             branch_taken;
    logic             muldiv_start;
    logic             dbg_halt_req;
    logic             dbg_step_req;
    logic             dbg_resume;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             muldiv_busy;
    logic             dbg_halted;
    logic [CNT_W-1:0] stall_cnt;

    // Controller side: consumes hazard/debug requests, produces enables.
    modport slave (
        input  load_use_hz, branch_taken, muldiv_start,
               dbg_halt_req, dbg_step_req, dbg_resume,
        output pc_write, ifid_write, ifid_flush, idex_write,
               idex_bubble, exmem_bubble, muldiv_busy, dbg_halted, stall_cnt
    );

    // Pipeline side: raises requests, obeys the enables.
    modport master (
        output load_use_hz, branch_taken, muldiv_start,
               dbg_halt_req, dbg_step_req, dbg_resume,
        input  pc_write, ifid_write, ifid_flush, idex_write,
               idex_bubble, exmem_bubble, muldiv_busy, dbg_halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline front end.
// Merges load-use stalls, branch flushes, multi-cycle MUL/DIV occupancy
// of EX and debug halt/step/resume into one set of register enables.
module pipeline_stall_controller #(
    parameter int MULDIV_LAT = 8,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    pipeline_stall_controller_if.slave     bus
);

    localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {RUN, MULDIV, HALT, STEP} state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic pcWrite, ifidWrite, ifidFlush, idexWrite;
    logic idexBubble, exmemBubble, muldivBusy, dbgHalted;
    logic acceptMuldiv;

    // A MUL/DIV only really enters EX when neither a flush nor a load-use bubble displaces it.
    assign acceptMuldiv = ((state_q == RUN) || (state_q == STEP)) &&
                          bus.muldiv_start && !bus.branch_taken && !bus.load_use_hz;

    // Pipeline-register enables, decoded from the current state and this cycle's hazards.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexWrite   = 1'b1;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        muldivBusy  = 1'b0;
        dbgHalted   = 1'b0;
        case (state_q)
            RUN, STEP: begin
                if (bus.branch_taken) begin
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                end else if (bus.load_use_hz) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                end
            end
            MULDIV: begin
                pcWrite     = 1'b0;
                ifidWrite   = 1'b0;
                idexWrite   = 1'b0;
                exmemBubble = 1'b1;
                muldivBusy  = 1'b1;
            end
            HALT: begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
                dbgHalted  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic: MUL/DIV freeze countdown, debug halt/step/resume and pending halt.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        halt_pend_d = halt_pend_q;
        if ((state_q != HALT) && bus.dbg_halt_req) begin
            halt_pend_d = 1'b1;
        end
        case (state_q)
            RUN: begin
                if (acceptMuldiv) begin
                    state_d = MULDIV;
                    cnt_d   = LAT_M1;
                    ret_d   = RUN;
                end else if (halt_pend_q) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                if (acceptMuldiv) begin
                    state_d = MULDIV;
                    cnt_d   = LAT_M1;
                    ret_d   = HALT;
                end else begin
                    state_d = HALT;
                end
            end
            MULDIV: begin
                if (cnt_q == '0) begin
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HALT: begin
                if (bus.dbg_resume) begin
                    state_d = RUN;
                end else if (bus.dbg_step_req) begin
                    state_d = STEP;
                end
            end
            default: state_d = RUN;
        endcase
        if ((state_d == HALT) && (state_q != HALT)) begin
            halt_pend_d = 1'b0;
        end
    end

    // State registers plus the saturating count of cycles the PC was frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            if (!pcWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_write     = pcWrite;
    assign bus.ifid_write   = ifidWrite;
    assign bus.ifid_flush   = ifidFlush;
    assign bus.idex_write   = idexWrite;
    assign bus.idex_bubble  = idexBubble;
    assign bus.exmem_bubble = exmemBubble;
    assign bus.muldiv_busy  = muldivBusy;
    assign bus.dbg_halted   = dbgHalted;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. Expected enables are
// hand-written per step; expected stall count is tracked from them.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;
    localparam int LAT   = 8;
    localparam logic [CNT_W-1:0] SAT = '1;

    // Enable patterns: {pc_write, ifid_write, ifid_flush, idex_write,
    //                   idex_bubble, exmem_bubble, muldiv_busy, dbg_halted}
    localparam logic [7:0] NORM = 8'b1101_0000;
    localparam logic [7:0] LU   = 8'b0001_1000;
    localparam logic [7:0] BR   = 8'b1111_1000;
    localparam logic [7:0] MD   = 8'b0000_0110;
    localparam logic [7:0] HLT  = 8'b0001_1001;

    // Input patterns: {load_use, branch, muldiv_start, halt_req, step_req, resume}
    localparam logic [5:0] I_IDLE  = 6'b000000;
    localparam logic [5:0] I_LU    = 6'b100000;
    localparam logic [5:0] I_BRLU  = 6'b110000;
    localparam logic [5:0] I_MDS   = 6'b001000;
    localparam logic [5:0] I_HALT  = 6'b000100;
    localparam logic [5:0] I_STEP  = 6'b000010;
    localparam logic [5:0] I_RES   = 6'b000001;
    localparam logic [5:0] I_RSST  = 6'b000011;
    localparam logic [5:0] I_MDHLT = 6'b110100;

    typedef struct {
        logic [7:0]       bits;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    logic [CNT_W-1:0] stallModel;
    int checks;
    int failures;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus();

    pipeline_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveInputs(input logic [5:0] in);
        {bus.load_use_hz, bus.branch_taken, bus.muldiv_start,
         bus.dbg_halt_req, bus.dbg_step_req, bus.dbg_resume} = in;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        logic [7:0] obs;
        e = sb.pop_front();
        obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
               bus.idex_bubble, bus.exmem_bubble, bus.muldiv_busy, bus.dbg_halted};
        checks++;
        assert (obs === e.bits) else begin
            failures++;
            $error("[TB] FAIL %s enables: got %b expected %b", tag, obs, e.bits);
        end
        checks++;
        assert (bus.stall_cnt === e.stall) else begin
            failures++;
            $error("[TB] FAIL %s stall_cnt: got %0d expected %0d", tag, bus.stall_cnt, e.stall);
        end
    endtask

    // One clock cycle: drive inputs, record expectation, sample mid-cycle, advance.
    task automatic applyStimulus(input logic [5:0] in, input logic [7:0] expBits, input string tag);
        exp_t e;
        driveInputs(in);
        e.bits  = expBits;
        e.stall = stallModel;
        sb.push_back(e);
        @(negedge clk);
        checkOutput(tag);
        if (!expBits[7] && (stallModel != SAT)) stallModel = stallModel + 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle, checked before release.
    task automatic midReset(input string tag);
        exp_t e;
        driveInputs(I_IDLE);
        #2;
        rst = 1'b1;
        #1;
        stallModel = '0;
        e.bits  = NORM;
        e.stall = '0;
        sb.push_back(e);
        checkOutput(tag);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        stallModel = '0;
        rst        = 1'b1;
        driveInputs(I_IDLE);
        #2;
        begin
            exp_t e;
            e.bits  = NORM;
            e.stall = '0;
            sb.push_back(e);
            checkOutput("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(I_IDLE, NORM, "idle");
        applyStimulus(I_LU,   LU,   "load_use");
        applyStimulus(I_IDLE, NORM, "after_lu");
        applyStimulus(I_BRLU, BR,   "branch_over_lu");

        applyStimulus(I_MDS, NORM, "muldiv_start");
        for (int i = 0; i < LAT; i++) applyStimulus(I_IDLE, MD, "muldiv_freeze");
        applyStimulus(I_IDLE, NORM, "muldiv_done");

        applyStimulus(I_MDS,  NORM, "muldiv_start2");
        applyStimulus(I_IDLE, MD,   "muldiv_c7");
        applyStimulus(I_IDLE, MD,   "muldiv_c6");
        midReset("reset_mid_muldiv");
        applyStimulus(I_IDLE, NORM, "post_reset");

        applyStimulus(I_MDS,   NORM, "muldiv_start3");
        applyStimulus(I_MDHLT, MD,   "halt_in_muldiv");
        for (int i = 1; i < LAT; i++) applyStimulus(I_IDLE, MD, "muldiv_freeze3");
        applyStimulus(I_IDLE, NORM, "run_before_halt");
        applyStimulus(I_IDLE, HLT,  "halted");
        applyStimulus(I_IDLE, HLT,  "halt_hold");
        applyStimulus(I_STEP, HLT,  "step_req");
        applyStimulus(I_IDLE, NORM, "step_cycle");
        applyStimulus(I_IDLE, HLT,  "back_halt");
        applyStimulus(I_RSST, HLT,  "resume_and_step");
        applyStimulus(I_IDLE, NORM, "resumed");
        applyStimulus(I_IDLE, NORM, "no_step_after_resume");

        applyStimulus(I_RSST, NORM, "dbg_ignored_in_run");
        applyStimulus(I_IDLE, NORM, "still_run");

        applyStimulus(I_HALT, NORM, "halt_req_run");
        applyStimulus(I_IDLE, NORM, "halt_pending");
        applyStimulus(I_IDLE, HLT,  "halted2");
        applyStimulus(I_STEP, HLT,  "step_req2");
        applyStimulus(I_MDS,  NORM, "step_muldiv");
        for (int i = 0; i < LAT; i++) applyStimulus(I_IDLE, MD, "step_freeze_sat");
        applyStimulus(I_IDLE, HLT,  "muldiv_ret_halt");
        applyStimulus(I_RES,  HLT,  "resume_req");
        applyStimulus(I_IDLE, NORM, "resumed2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
